// File: rtl/mem_pkg.sv
// Shared types and defaults for the single-outstanding RAM access controller.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // RAM read/write select polarity
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int unsigned DEF_DEPTH = 256;
  localparam int unsigned DEF_LAT   = 2;

endpackage

// File: rtl/mem_ctrl.sv
// Single-outstanding RAM access controller: request handshake in, fixed-latency RAM access, response out.
// Optional out-of-range rejection compiled in with `define MEM_CTRL_RANGE_CHECK_EN.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned LAT    = DEF_LAT    // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_q
);

  state_t     state;
  logic [3:0] lat_cnt;
  logic       accept;
  logic       range_err;

  // Handshake and RAM strobes decode straight from state so reset drops them at once.
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign mem_en    = (state == ISSUE) || (state == WAIT);
  assign accept    = req_valid && req_ready;

`ifdef MEM_CTRL_RANGE_CHECK_EN
  assign range_err = (32'(req_addr) >= 32'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err <= 1'b0;
    end else if (accept) begin
      rsp_err <= range_err;
    end
  end
`else
  assign range_err = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      rsp_rdata <= '0;
      mem_rw    <= RW_READ;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mem_rw    <= req_rw;
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
            if (range_err) begin
              rsp_rdata <= '0;
              state     <= RESP;
            end else begin
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          lat_cnt <= 4'(LAT);
          state   <= WAIT;
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          // Last cycle of the access window: RAM output is valid now.
          if (lat_cnt == 4'd1) begin
            if (mem_rw == RW_READ) begin
              rsp_rdata <= mem_q;
            end
            state <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
